// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order prediction FIFO checked against EX results, with redirect, flush and predictor training.
// Define BRANCH_STATS_EN to add saturating branch/mispredict counters (stat_branches, stat_mispred).
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  logic [63:0] pred_pc,
    input  logic        pred_taken,
    input  logic [63:0] pred_target,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [63:0] res_pc,
    input  logic        res_taken,
    input  logic [63:0] res_target,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        flush,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [63:0] upd_pc,
    output logic        upd_taken,
    output logic        err_seq
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    logic [63:0]      pc_mem  [DEPTH];
    logic             tkn_mem [DEPTH];
    logic [63:0]      tgt_mem [DEPTH];

    state_t           state_reg;
    logic [2:0]       flush_cnt_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             redirect_valid_reg;
    logic [63:0]      redirect_pc_reg;
    logic             flush_reg;
    logic             upd_valid_reg;
    logic [63:0]      upd_pc_reg;
    logic             upd_taken_reg;
    logic             err_seq_reg;

    logic             empty;
    logic             full;
    logic             in_run;
    logic             upd_stall;
    logic             pop;
    logic             push;
    logic [63:0]      head_pc;
    logic             head_taken;
    logic [63:0]      head_tgt;
    logic             pc_err;
    logic             mispredict;
    logic             empty_err;
    logic [63:0]      redirect_pc_next;

    always_comb begin
        empty      = (count_reg == '0);
        full       = (count_reg == CNT_W'(DEPTH));
        in_run     = (state_reg == ST_RUN);
        upd_stall  = upd_valid_reg & ~upd_ready;
        res_ready  = ~empty & ~upd_stall & in_run;
        pop        = res_valid & res_ready;
        pred_ready = in_run & (~full | pop);
        push       = pred_valid & pred_ready;

        head_pc    = pc_mem[rd_ptr_reg];
        head_taken = tkn_mem[rd_ptr_reg];
        head_tgt   = tgt_mem[rd_ptr_reg];

        // A PC mismatch means the pipelines lost sync; recover the same way as a wrong guess.
        pc_err     = (head_pc != res_pc);
        mispredict = pop & (pc_err | (head_taken != res_taken) |
                            (head_taken & res_taken & (head_tgt != res_target)));
        empty_err  = res_valid & empty & in_run;

        redirect_pc_next = res_taken ? res_target : (res_pc + 64'd4);
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]  <= pred_pc;
            tkn_mem[wr_ptr_reg] <= pred_taken;
            tgt_mem[wr_ptr_reg] <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= ST_RUN;
            flush_cnt_reg      <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            flush_reg          <= 1'b0;
            upd_valid_reg      <= 1'b0;
            upd_pc_reg         <= '0;
            upd_taken_reg      <= 1'b0;
            err_seq_reg        <= 1'b0;
        end else begin
            redirect_valid_reg <= mispredict;
            if (mispredict)
                redirect_pc_reg <= redirect_pc_next;

            // Mispredict squashes every queued prediction, including one pushed this cycle.
            if (mispredict) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end

            case (state_reg)
                ST_RUN: begin
                    if (mispredict) begin
                        state_reg     <= ST_FLUSH;
                        flush_cnt_reg <= 3'(FLUSH_CYCLES);
                        flush_reg     <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_reg == 3'd1) begin
                        state_reg     <= ST_RUN;
                        flush_cnt_reg <= '0;
                        flush_reg     <= 1'b0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_RUN;
                    flush_cnt_reg <= '0;
                    flush_reg     <= 1'b0;
                end
            endcase

            if (pop) begin
                upd_valid_reg <= 1'b1;
                upd_pc_reg    <= res_pc;
                upd_taken_reg <= res_taken;
            end else if (upd_ready) begin
                upd_valid_reg <= 1'b0;
            end

            if ((pop & pc_err) | empty_err)
                err_seq_reg <= 1'b1;
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush          = flush_reg;
    assign upd_valid      = upd_valid_reg;
    assign upd_pc         = upd_pc_reg;
    assign upd_taken      = upd_taken_reg;
    assign err_seq        = err_seq_reg;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispred_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_branches_reg <= '0;
            stat_mispred_reg  <= '0;
        end else begin
            if (pop && stat_branches_reg != 32'hFFFF_FFFF)
                stat_branches_reg <= stat_branches_reg + 1'b1;
            if (mispredict && stat_mispred_reg != 32'hFFFF_FFFF)
                stat_mispred_reg <= stat_mispred_reg + 1'b1;
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_mispred  = stat_mispred_reg;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_branch_resolve_unit;
    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid, pred_ready, pred_taken;
    logic [63:0] pred_pc, pred_target;
    logic        res_valid, res_ready, res_taken;
    logic [63:0] res_pc, res_target;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush;
    logic        upd_valid, upd_ready, upd_taken;
    logic [63:0] upd_pc;
    logic        err_seq;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .err_seq(err_seq)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] tgt;
    } pred_t;

    pred_t           q[$];
    int              flush_left;
    logic            m_redir_v;
    logic [63:0]     m_redir_pc;
    logic            m_upd_v;
    logic [63:0]     m_upd_pc;
    logic            m_upd_t;
    logic            m_err;
    longint unsigned m_branches, m_mispred;
    int              passed = 0;
    int              total  = 0;
    logic            s_pred_ready, s_res_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        flush_left = 0;
        m_redir_v  = 1'b0;
        m_redir_pc = '0;
        m_upd_v    = 1'b0;
        m_upd_pc   = '0;
        m_upd_t    = 1'b0;
        m_err      = 1'b0;
        m_branches = 0;
        m_mispred  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        upd_ready  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_redirect_valid", redirect_valid, 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_flush", flush, 64'd0);
        chk("rst_upd_valid", upd_valid, 64'd0);
        chk("rst_upd_pc", upd_pc, 64'd0);
        chk("rst_upd_taken", upd_taken, 64'd0);
        chk("rst_err_seq", err_seq, 64'd0);
    endtask

    // One clock of traffic: drive, check handshakes, advance the model, check registered outputs.
    task automatic step(input logic pv, input logic [63:0] ppc, input logic ptk, input logic [63:0] ptgt,
                        input logic rv, input logic [63:0] rpc, input logic rtk, input logic [63:0] rtgt,
                        input logic ur);
        bit    exp_rr, exp_pr, pop, push, mis;
        pred_t h;
        pred_t n;
        @(negedge clk);
        reset       = 1'b1;
        pred_valid  = pv;
        pred_pc     = ppc;
        pred_taken  = ptk;
        pred_target = ptgt;
        res_valid   = rv;
        res_pc      = rpc;
        res_taken   = rtk;
        res_target  = rtgt;
        upd_ready   = ur;
        #1;
        exp_rr = (q.size() > 0) && !(m_upd_v && !ur) && (flush_left == 0);
        pop    = rv && exp_rr;
        exp_pr = (flush_left == 0) && ((q.size() < DEPTH) || pop);
        push   = pv && exp_pr;
        s_pred_ready = pred_ready;
        s_res_ready  = res_ready;
        chk("res_ready", res_ready, exp_rr);
        chk("pred_ready", pred_ready, exp_pr);

        mis = 1'b0;
        if (rv && q.size() == 0 && flush_left == 0) m_err = 1'b1;
        if (pop) begin
            h   = q.pop_front();
            mis = (h.pc != rpc) || (h.taken != rtk) || (h.taken && rtk && h.tgt != rtgt);
            if (h.pc != rpc) m_err = 1'b1;
            m_branches++;
            if (mis) m_mispred++;
        end
        if (push) begin
            n.pc = ppc; n.taken = ptk; n.tgt = ptgt;
            q.push_back(n);
        end
        if (mis) q.delete();

        m_redir_v = mis;
        if (mis) m_redir_pc = rtk ? rtgt : rpc + 64'd4;
        if (pop) begin
            m_upd_v  = 1'b1;
            m_upd_pc = rpc;
            m_upd_t  = rtk;
        end else if (ur) begin
            m_upd_v = 1'b0;
        end
        if (mis) flush_left = FLUSH_CYCLES;
        else if (flush_left > 0) flush_left--;

        @(posedge clk);
        #1;
        chk("redirect_valid", redirect_valid, m_redir_v);
        if (m_redir_v) chk("redirect_pc", redirect_pc, m_redir_pc);
        chk("flush", flush, (flush_left > 0));
        chk("upd_valid", upd_valid, m_upd_v);
        if (m_upd_v) begin
            chk("upd_pc", upd_pc, m_upd_pc);
            chk("upd_taken", upd_taken, m_upd_t);
        end
        chk("err_seq", err_seq, m_err);
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, (m_branches > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_branches);
        chk("stat_mispred", stat_mispred, (m_mispred > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mispred);
`endif
    endtask

    task automatic push_pred(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
        step(1'b1, pc, tk, tgt, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic resolve(input logic [63:0] pc, input logic tk, input logic [63:0] tgt, input logic ur);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, pc, tk, tgt, ur);
    endtask

    task automatic idle(input logic ur);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, ur);
    endtask

    initial begin
        logic [63:0] exp_pcs [4];
        logic        exp_tks [4];
        logic [63:0] exp_tgs [4];
        logic        pv, ptk, rv, rtk, ur;
        logic [63:0] ppc, ptgt, rpc, rtgt;

        reset = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0; upd_ready = 1'b0;
        model_reset();
        do_reset();

        // Correct prediction
        push_pred(64'h100, 1'b1, 64'h140);
        resolve(64'h100, 1'b1, 64'h140, 1'b1);
        chk("c22_upd_valid", upd_valid, 64'd1);
        chk("c22_upd_pc", upd_pc, 64'h100);
        chk("c22_upd_taken", upd_taken, 64'd1);
        chk("c22_no_redirect", redirect_valid, 64'd0);
        chk("c22_no_flush", flush, 64'd0);
        idle(1'b1);

        // Direction mispredict with a same-cycle push that must be discarded
        push_pred(64'h200, 1'b0, 64'h0);
        step(1'b1, 64'h999, 1'b0, 64'h0, 1'b1, 64'h200, 1'b1, 64'h180, 1'b1);
        chk("c23_redirect_valid", redirect_valid, 64'd1);
        chk("c23_redirect_pc", redirect_pc, 64'h180);
        chk("c23_flush_1", flush, 64'd1);
        idle(1'b1);
        chk("c23_redirect_pulse", redirect_valid, 64'd0);
        chk("c23_flush_2", flush, 64'd1);
        idle(1'b1);
        chk("c23_flush_done", flush, 64'd0);

        // Not-taken correction
        push_pred(64'h300, 1'b1, 64'h340);
        resolve(64'h300, 1'b0, 64'h0, 1'b1);
        chk("c24_redirect_valid", redirect_valid, 64'd1);
        chk("c24_redirect_pc", redirect_pc, 64'h304);
        chk("c24_no_seq_err", err_seq, 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Fall-through PC wraps at the top of the address space
        push_pred(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h10);
        resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b1);
        chk("wrap_redirect_pc", redirect_pc, 64'h0);
        idle(1'b1);
        idle(1'b1);

        // Full FIFO, then simultaneous push and pop
        for (int i = 0; i < 4; i++)
            push_pred(64'h400 + 64'(i) * 64'h10, i[0], 64'h800 + 64'(i));
        step(1'b1, 64'h4F0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        chk("c25_full_pred_ready", s_pred_ready, 64'd0);
        step(1'b1, 64'h440, 1'b0, 64'h0, 1'b1, 64'h400, 1'b0, 64'h0, 1'b1);
        chk("c25_pushpop_pred_ready", s_pred_ready, 64'd1);
        chk("c25_pushpop_upd_pc", upd_pc, 64'h400);
        step(1'b1, 64'h450, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        chk("c25_still_full", s_pred_ready, 64'd0);
        exp_pcs = '{64'h410, 64'h420, 64'h430, 64'h440};
        exp_tks = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_tgs = '{64'h801, 64'h0, 64'h803, 64'h0};
        for (int i = 0; i < 4; i++) begin
            resolve(exp_pcs[i], exp_tks[i], exp_tgs[i], 1'b1);
            chk("c25_order_upd_pc", upd_pc, exp_pcs[i]);
            chk("c25_order_no_redirect", redirect_valid, 64'd0);
        end
        idle(1'b1);

        // Training backpressure
        push_pred(64'h500, 1'b0, 64'h0);
        push_pred(64'h510, 1'b0, 64'h0);
        resolve(64'h500, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            resolve(64'h510, 1'b0, 64'h0, 1'b0);
            chk("c26_res_ready_low", s_res_ready, 64'd0);
            chk("c26_upd_valid_held", upd_valid, 64'd1);
            chk("c26_upd_pc_held", upd_pc, 64'h500);
        end
        resolve(64'h510, 1'b0, 64'h0, 1'b1);
        chk("c26_res_ready_release", s_res_ready, 64'd1);
        chk("c26_next_upd_pc", upd_pc, 64'h510);
        idle(1'b1);
        chk("c26_upd_drained", upd_valid, 64'd0);

        // Sequence errors, then reset mid-flush
        resolve(64'h600, 1'b1, 64'h0, 1'b1);
        chk("c27_err_set", err_seq, 64'd1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("c27_err_sticky", err_seq, 64'd1);
        push_pred(64'h700, 1'b0, 64'h0);
        resolve(64'h700, 1'b1, 64'h780, 1'b0);
        chk("c27_in_flush", flush, 64'd1);
        do_reset();
        idle(1'b0);
        chk("c27_no_redirect_after_reset", redirect_valid, 64'd0);
        chk("c27_no_upd_after_reset", upd_valid, 64'd0);

        // Randomized traffic with mostly-consistent resolutions
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            pv   = ($urandom % 4) != 0;
            ppc  = {$urandom, $urandom} & ~64'h3;
            ptk  = 1'($urandom % 2);
            ptgt = {$urandom, $urandom} & ~64'h3;
            rv   = ($urandom % 3) != 0;
            ur   = ($urandom % 4) != 0;
            if (q.size() > 0) begin
                rpc  = (($urandom % 60) == 0) ? ({$urandom, $urandom} & ~64'h3) : q[0].pc;
                rtk  = (($urandom % 8) == 0) ? ~q[0].taken : q[0].taken;
                rtgt = (($urandom % 8) == 0) ? ({$urandom, $urandom} & ~64'h3) : q[0].tgt;
            end else begin
                rv   = (($urandom % 20) == 0);
                rpc  = {$urandom, $urandom} & ~64'h3;
                rtk  = 1'($urandom % 2);
                rtgt = {$urandom, $urandom} & ~64'h3;
            end
            step(pv, ppc, ptk, ptgt, rv, rpc, rtk, rtgt, ur);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
